// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the two requesting ports, the arbiter and the SRAM controller.
// The master modport is the arbiter's view; slave is the view of the surrounding environment.
interface sram_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          a_req;
    logic          a_wr_req;
    logic          a_rd_req;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_valid;
    logic          a_err;

    logic          b_req;
    logic          b_wr_req;
    logic          b_rd_req;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_valid;
    logic          b_err;

    logic          m_req;
    logic          m_wr_req;
    logic          m_rd_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_valid;

    logic [1:0]    overrun;

    modport master (
        input  a_req, a_wr_req, a_rd_req, a_addr, a_wdata,
        output a_rdata, a_valid, a_err,
        input  b_req, b_wr_req, b_rd_req, b_addr, b_wdata,
        output b_rdata, b_valid, b_err,
        output m_req, m_wr_req, m_rd_req, m_addr, m_wdata,
        input  m_rdata, m_valid,
        output overrun
    );

    modport slave (
        output a_req, a_wr_req, a_rd_req, a_addr, a_wdata,
        input  a_rdata, a_valid, a_err,
        output b_req, b_wr_req, b_rd_req, b_addr, b_wdata,
        input  b_rdata, b_valid, b_err,
        input  m_req, m_wr_req, m_rd_req, m_addr, m_wdata,
        output m_rdata, m_valid,
        input  overrun
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one SRAM controller command port: round-robin or locked grant,
// one outstanding command, completion routing back to the issuer and a controller timeout.
module sram_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               s_clk,
    input  logic               s_rst,
    sram_port_arbiter_if.master bus
);
    localparam bit      TO_EN    = (TIMEOUT != 0);
    localparam int      CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT - 1 : 0);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic {PORT_A, PORT_B}   port_t;

    state_t        state;
    port_t         owner;
    port_t         last_grant;
    port_t         lock_own;
    logic          lock_vld;
    logic          cur_rd;
    logic [CW-1:0] cnt;

    logic          pend_a, pend_b;
    logic          pa_rd, pb_rd;
    logic [AW-1:0] pa_addr, pb_addr;
    logic [DW-1:0] pa_wdata, pb_wdata;

    logic          is_idle, lock_hold, elig_a, elig_b, gnt_a, gnt_b, gnt, gnt_req;
    port_t         gnt_port;
    logic          sel_rd;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          timeout_hit, done;
    logic          pulse_a, pulse_b, acc_a, acc_b;
    logic          lock_vld_nxt, mreq_nxt;
    port_t         lock_own_nxt;

    always_comb begin
        is_idle   = (state == ST_IDLE);
        // A lock whose owner has dropped req is released in the same IDLE cycle it is seen.
        lock_hold = lock_vld && ((lock_own == PORT_A) ? bus.a_req : bus.b_req);
        elig_a    = pend_a && (!lock_hold || lock_own == PORT_A);
        elig_b    = pend_b && (!lock_hold || lock_own == PORT_B);
        gnt_a     = is_idle && elig_a && (!elig_b || last_grant == PORT_B);
        gnt_b     = is_idle && elig_b && !gnt_a;
        gnt       = gnt_a || gnt_b;
        gnt_port  = gnt_b ? PORT_B : PORT_A;
        gnt_req   = gnt_b ? bus.b_req : bus.a_req;
        sel_rd    = gnt_b ? pb_rd : pa_rd;
        sel_addr  = gnt_b ? pb_addr : pa_addr;
        sel_wdata = gnt_b ? pb_wdata : pa_wdata;

        timeout_hit = TO_EN && (cnt == CNT_LAST);
        done        = (state == ST_WAIT) && (bus.m_valid || timeout_hit);

        // The outstanding flag clears at the completion edge, so a pulse on that edge is taken.
        pulse_a = bus.a_wr_req || bus.a_rd_req;
        pulse_b = bus.b_wr_req || bus.b_rd_req;
        acc_a   = !pend_a && !((state == ST_WAIT) && owner == PORT_A && !done);
        acc_b   = !pend_b && !((state == ST_WAIT) && owner == PORT_B && !done);

        lock_vld_nxt = lock_vld;
        lock_own_nxt = lock_own;
        if (is_idle) begin
            lock_vld_nxt = lock_hold;
            if (gnt && gnt_req) begin
                lock_vld_nxt = 1'b1;
                lock_own_nxt = gnt_port;
            end
        end
        mreq_nxt = (is_idle ? gnt : !done) || lock_vld_nxt;
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state        <= ST_IDLE;
            owner        <= PORT_A;
            last_grant   <= PORT_B;
            lock_own     <= PORT_A;
            lock_vld     <= 1'b0;
            cur_rd       <= 1'b0;
            cnt          <= '0;
            pend_a       <= 1'b0;
            pend_b       <= 1'b0;
            pa_rd        <= 1'b0;
            pb_rd        <= 1'b0;
            pa_addr      <= '0;
            pb_addr      <= '0;
            pa_wdata     <= '0;
            pb_wdata     <= '0;
            bus.a_rdata  <= '0;
            bus.a_valid  <= 1'b0;
            bus.a_err    <= 1'b0;
            bus.b_rdata  <= '0;
            bus.b_valid  <= 1'b0;
            bus.b_err    <= 1'b0;
            bus.m_req    <= 1'b0;
            bus.m_wr_req <= 1'b0;
            bus.m_rd_req <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.overrun  <= '0;
        end else begin
            bus.a_valid  <= 1'b0;
            bus.a_err    <= 1'b0;
            bus.b_valid  <= 1'b0;
            bus.b_err    <= 1'b0;
            bus.m_wr_req <= 1'b0;
            bus.m_rd_req <= 1'b0;
            bus.m_req    <= mreq_nxt;
            lock_vld     <= lock_vld_nxt;
            lock_own     <= lock_own_nxt;

            if (state == ST_IDLE) begin
                if (gnt) begin
                    state        <= ST_WAIT;
                    cnt          <= '0;
                    owner        <= gnt_port;
                    last_grant   <= gnt_port;
                    cur_rd       <= sel_rd;
                    bus.m_addr   <= sel_addr;
                    bus.m_wdata  <= sel_wdata;
                    bus.m_rd_req <= sel_rd;
                    bus.m_wr_req <= !sel_rd;
                    if (gnt_a) pend_a <= 1'b0;
                    else       pend_b <= 1'b0;
                end
            end else begin
                if (done) begin
                    state <= ST_IDLE;
                    if (owner == PORT_A) begin
                        bus.a_valid <= 1'b1;
                        bus.a_err   <= !bus.m_valid;
                        if (!bus.m_valid)  bus.a_rdata <= '0;
                        else if (cur_rd)   bus.a_rdata <= bus.m_rdata;
                    end else begin
                        bus.b_valid <= 1'b1;
                        bus.b_err   <= !bus.m_valid;
                        if (!bus.m_valid)  bus.b_rdata <= '0;
                        else if (cur_rd)   bus.b_rdata <= bus.m_rdata;
                    end
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Capture and grant never touch the same latch on one edge: one needs it empty, the other full.
            if (pulse_a) begin
                if (acc_a) begin
                    pend_a   <= 1'b1;
                    pa_rd    <= bus.a_rd_req;
                    pa_addr  <= bus.a_addr;
                    pa_wdata <= bus.a_wdata;
                end else begin
                    bus.overrun[0] <= 1'b1;
                end
            end
            if (pulse_b) begin
                if (acc_b) begin
                    pend_b   <= 1'b1;
                    pb_rd    <= bus.b_rd_req;
                    pb_addr  <= bus.b_addr;
                    pb_wdata <= bus.b_wdata;
                end else begin
                    bus.overrun[1] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a scoreboard of expected controller commands
// and per-port completions, plus a small behavioural SRAM controller.
module tb_sram_port_arbiter;
    typedef struct packed {logic rd; logic [15:0] addr; logic [15:0] wdata;} cmd_t;
    typedef struct packed {logic [15:0] rdata; logic err;} comp_t;

    logic s_clk = 1'b0;
    logic s_rst;
    int   checks = 0;
    int   errors = 0;

    cmd_t  exp_cmd[$];
    comp_t qa[$];
    comp_t qb[$];
    logic [15:0] last_a = '0, last_b = '0;
    logic [15:0] hold_a = '0, hold_b = '0;

    int   ctrl_delay = 3;
    bit   ctrl_stall = 1'b0;
    int   inj_req = 0, inj_done = 0;
    bit   c_pend = 1'b0, c_rd = 1'b0;
    int   c_cnt = 0;
    logic [15:0] c_addr = '0;

    sram_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    sram_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .bus   (bus.master)
    );

    always #5 s_clk = ~s_clk;

    // Controller model: answers ctrl_delay cycles after the command cycle; reads return addr^ACDB.
    always @(negedge s_clk) begin
        bus.m_valid = 1'b0;
        if (inj_req != inj_done) begin
            inj_done     = inj_req;
            bus.m_valid  = 1'b1;
            bus.m_rdata  = 16'hDEAD;
        end else if (bus.m_rd_req || bus.m_wr_req) begin
            if (!ctrl_stall) begin
                c_pend = 1'b1;
                c_cnt  = ctrl_delay;
                c_rd   = bus.m_rd_req;
                c_addr = bus.m_addr;
            end
        end else if (c_pend) begin
            c_cnt = c_cnt - 1;
            if (c_cnt == 0) begin
                c_pend      = 1'b0;
                bus.m_valid = 1'b1;
                bus.m_rdata = c_rd ? (c_addr ^ 16'hACDB) : 16'h5555;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor_step();
        cmd_t  c;
        comp_t e;
        if (s_rst) begin
            hold_a = '0;
            hold_b = '0;
        end else begin
            if (bus.a_valid) begin
                if (qa.size() == 0) chk("a_unexpected_valid", 32'(bus.a_valid), 0);
                else begin
                    e = qa.pop_front();
                    chk("a_rdata", 32'(bus.a_rdata), 32'(e.rdata));
                    chk("a_err", 32'(bus.a_err), 32'(e.err));
                    chk("b_rdata_hold", 32'(bus.b_rdata), 32'(hold_b));
                    hold_a = e.rdata;
                end
            end
            if (bus.b_valid) begin
                if (qb.size() == 0) chk("b_unexpected_valid", 32'(bus.b_valid), 0);
                else begin
                    e = qb.pop_front();
                    chk("b_rdata", 32'(bus.b_rdata), 32'(e.rdata));
                    chk("b_err", 32'(bus.b_err), 32'(e.err));
                    chk("a_rdata_hold", 32'(bus.a_rdata), 32'(hold_a));
                    hold_b = e.rdata;
                end
            end
            if (bus.m_rd_req || bus.m_wr_req) begin
                if (exp_cmd.size() == 0) chk("m_unexpected_cmd", 32'(bus.m_addr), 32'hFFFF_FFFF);
                else begin
                    c = exp_cmd.pop_front();
                    chk("m_rd_req", 32'(bus.m_rd_req), 32'(c.rd));
                    chk("m_wr_req", 32'(bus.m_wr_req), 32'(!c.rd));
                    chk("m_addr", 32'(bus.m_addr), 32'(c.addr));
                    if (!c.rd) chk("m_wdata", 32'(bus.m_wdata), 32'(c.wdata));
                end
            end
        end
    endtask

    task automatic drive(input logic port, input logic rd, input logic [15:0] addr, input logic [15:0] wdata);
        if (!port) begin
            bus.a_rd_req = rd; bus.a_wr_req = !rd; bus.a_addr = addr; bus.a_wdata = wdata;
        end else begin
            bus.b_rd_req = rd; bus.b_wr_req = !rd; bus.b_addr = addr; bus.b_wdata = wdata;
        end
    endtask

    task automatic clear_pulses();
        bus.a_rd_req = 1'b0; bus.a_wr_req = 1'b0;
        bus.b_rd_req = 1'b0; bus.b_wr_req = 1'b0;
    endtask

    task automatic push_cmd(input logic rd, input logic [15:0] addr, input logic [15:0] wdata);
        cmd_t c;
        c.rd = rd; c.addr = addr; c.wdata = wdata;
        exp_cmd.push_back(c);
    endtask

    task automatic push_comp(input logic port, input logic rd, input logic [15:0] addr, input logic err);
        comp_t c;
        logic [15:0] r;
        if (err)     r = '0;
        else if (rd) r = addr ^ 16'hACDB;
        else         r = port ? last_b : last_a;
        if (port) last_b = r; else last_a = r;
        c.rdata = r; c.err = err;
        if (port) qb.push_back(c); else qa.push_back(c);
    endtask

    task automatic issue(input logic port, input logic rd, input logic [15:0] addr, input logic [15:0] wdata);
        @(negedge s_clk);
        drive(port, rd, addr, wdata);
        push_cmd(rd, addr, wdata);
        push_comp(port, rd, addr, 1'b0);
        @(negedge s_clk);
        clear_pulses();
    endtask

    task automatic drain(input string tag);
        bit empty = 1'b0;
        for (int i = 0; i < 60 && !empty; i++) begin
            @(negedge s_clk);
            empty = (qa.size() == 0) && (qb.size() == 0) && (exp_cmd.size() == 0);
        end
        chk(tag, 32'(empty), 1);
        @(negedge s_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.a_valid, bus.a_err, bus.b_valid, bus.b_err, bus.m_req,
                                bus.m_wr_req, bus.m_rd_req, bus.overrun}), 0);
        chk({tag, "_rdata"}, {bus.a_rdata, bus.b_rdata}, 0);
        chk({tag, "_mbus"}, {bus.m_addr, bus.m_wdata}, 0);
    endtask

    initial begin
        bit got;
        s_rst = 1'b1;
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = '0; bus.b_wdata = '0;
        clear_pulses();
        fork
            forever begin
                @(negedge s_clk);
                monitor_step();
            end
        join_none

        repeat (2) @(negedge s_clk);
        chk_all_zero("reset");
        s_rst = 1'b0;

        // Single read on port A: command on the bus two cycles after the pulse.
        ctrl_delay = 3;
        @(negedge s_clk);
        drive(1'b0, 1'b1, 16'h1234, 16'h0000);
        push_cmd(1'b1, 16'h1234, 16'h0000);
        push_comp(1'b0, 1'b1, 16'h1234, 1'b0);
        @(negedge s_clk);
        clear_pulses();
        chk("rd_latency_early", 32'(bus.m_rd_req), 0);
        @(negedge s_clk);
        chk("rd_latency_req", 32'(bus.m_rd_req), 1);
        chk("rd_latency_addr", 32'(bus.m_addr), 32'h1234);
        drain("drain_single_read");

        // Simultaneous A write / B read; last grant was A, so B wins each tie and grants alternate.
        for (int i = 0; i < 4; i++) begin
            @(negedge s_clk);
            drive(1'b0, 1'b0, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
            drive(1'b1, 1'b1, 16'h0200 + 16'(i), 16'h0000);
            push_cmd(1'b1, 16'h0200 + 16'(i), 16'h0000);
            push_cmd(1'b0, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
            push_comp(1'b1, 1'b1, 16'h0200 + 16'(i), 1'b0);
            push_comp(1'b0, 1'b0, 16'h0100 + 16'(i), 1'b0);
            @(negedge s_clk);
            clear_pulses();
            drain("drain_alternate");
        end

        // Lock: B holds req while A waits pending.
        @(negedge s_clk);
        bus.b_req = 1'b1;
        drive(1'b1, 1'b1, 16'h0300, 16'h0000);
        push_cmd(1'b1, 16'h0300, 16'h0000);
        push_comp(1'b1, 1'b1, 16'h0300, 1'b0);
        @(negedge s_clk);
        clear_pulses();
        drive(1'b0, 1'b0, 16'h0400, 16'h1111);
        push_comp(1'b0, 1'b0, 16'h0400, 1'b0);
        @(negedge s_clk);
        clear_pulses();
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge s_clk);
                chk("lock_m_req", 32'(bus.m_req), 1);
                if (bus.b_valid) got = 1'b1;
            end
            chk("lock_b_done", 32'(got), 1);
            if (k < 2) begin
                drive(1'b1, 1'b1, 16'h0301 + 16'(k), 16'h0000);
                push_cmd(1'b1, 16'h0301 + 16'(k), 16'h0000);
                push_comp(1'b1, 1'b1, 16'h0301 + 16'(k), 1'b0);
                @(negedge s_clk);
                clear_pulses();
            end else begin
                bus.b_req = 1'b0;
                push_cmd(1'b0, 16'h0400, 16'h1111);
                @(negedge s_clk);
                chk("unlock_a_grant", 32'(bus.m_wr_req), 1);
                chk("unlock_a_addr", 32'(bus.m_addr), 32'h0400);
                chk("unlock_m_req", 32'(bus.m_req), 1);
            end
        end
        drain("drain_lock");
        chk("no_overrun_yet", 32'(bus.overrun), 0);

        // Overrun: second A pulse while the first is outstanding; controller stalled -> timeout.
        ctrl_stall = 1'b1;
        @(negedge s_clk);
        drive(1'b0, 1'b0, 16'h0500, 16'h2222);
        push_cmd(1'b0, 16'h0500, 16'h2222);
        push_comp(1'b0, 1'b0, 16'h0500, 1'b1);
        @(negedge s_clk);
        clear_pulses();
        @(negedge s_clk);
        drive(1'b0, 1'b0, 16'h0600, 16'h3333);
        @(negedge s_clk);
        clear_pulses();
        chk("overrun_set", 32'(bus.overrun), 32'h1);
        drain("drain_overrun");
        chk("overrun_sticky", 32'(bus.overrun), 32'h1);

        // Timeout on port B read: completion with err exactly 8 cycles after the issue cycle.
        @(negedge s_clk);
        drive(1'b1, 1'b1, 16'h0700, 16'h0000);
        push_cmd(1'b1, 16'h0700, 16'h0000);
        push_comp(1'b1, 1'b1, 16'h0700, 1'b1);
        @(negedge s_clk);
        clear_pulses();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.m_rd_req) got = 1'b1;
            else @(negedge s_clk);
        end
        chk("timeout_issue_seen", 32'(got), 1);
        got = 1'b0;
        repeat (7) begin
            @(negedge s_clk);
            if (bus.b_valid) got = 1'b1;
        end
        chk("timeout_not_early", 32'(got), 0);
        @(negedge s_clk);
        chk("timeout_valid", 32'(bus.b_valid), 1);
        chk("timeout_err", 32'(bus.b_err), 1);
        chk("timeout_rdata", 32'(bus.b_rdata), 0);
        ctrl_stall = 1'b0;
        @(negedge s_clk);
        inj_req++;
        got = 1'b0;
        repeat (4) begin
            @(negedge s_clk);
            if (bus.a_valid || bus.b_valid) got = 1'b1;
        end
        chk("late_valid_ignored", 32'(got), 0);
        issue(1'b1, 1'b1, 16'h0800, 16'h0000);
        drain("drain_after_timeout");
        chk("overrun_sticky2", 32'(bus.overrun), 32'h1);

        // Reset during WAIT: everything clears at once, the abandoned command never completes.
        ctrl_delay = 5;
        @(negedge s_clk);
        drive(1'b0, 1'b1, 16'h0900, 16'h0000);
        push_cmd(1'b1, 16'h0900, 16'h0000);
        @(negedge s_clk);
        clear_pulses();
        @(negedge s_clk);
        chk("rst_cmd_issued", 32'(bus.m_rd_req), 1);
        @(negedge s_clk);
        s_rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        last_a = '0;
        last_b = '0;
        repeat (2) @(negedge s_clk);
        s_rst = 1'b0;
        got = 1'b0;
        repeat (6) begin
            @(negedge s_clk);
            if (bus.a_valid || bus.b_valid || bus.m_rd_req || bus.m_wr_req) got = 1'b1;
        end
        chk("rst_no_completion", 32'(got), 0);
        ctrl_delay = 2;
        issue(1'b0, 1'b0, 16'h0A00, 16'h4444);
        drain("drain_post_reset_wr");
        issue(1'b0, 1'b1, 16'h0A00, 16'h0000);
        drain("drain_post_reset_rd");
        chk("overrun_after_reset", 32'(bus.overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
